// File: rtl/uart_tx_if.sv
// Byte-wide valid/ready handshake into the UART transmitter's one-entry holding register.
interface uart_tx_if;
  logic [7:0] iTxByte;
  logic       iTxValid;
  logic       oTxReady;

  modport master (output iTxByte, output iTxValid, input oTxReady);
  modport slave  (input iTxByte, input iTxValid, output oTxReady);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, CLKS_PER_BIT clocks per bit; accept-to-done latency 10N+2.
// One-entry holding register: ready drops while a byte is queued, so frames run back-to-back.
module uart_tx #(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic      iClk,
  input  logic      iRst,
  uart_tx_if.slave  tx,
  output logic      oTxSerial,
  output logic      oTxBusy,
  output logic      oTxDone
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    sIDLE     = 3'd0,
    sTX_START = 3'd1,
    sTX_DATA  = 3'd2,
    sTX_STOP  = 3'd3,
    sDONE     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic             serial_q, serial_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             bit_end;

  assign accept  = tx.iTxValid & ~hold_full_q;
  assign bit_end = (clk_cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    clk_cnt_d   = clk_cnt_q;
    serial_d    = 1'b1;
    busy_d      = (state_q != sIDLE);
    done_d      = (state_q == sDONE);

    // accept only when empty, so it never collides with the hold->shift transfer below
    if (accept) begin
      hold_d      = tx.iTxByte;
      hold_full_d = 1'b1;
    end

    case (state_q)
      sIDLE, sDONE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          clk_cnt_d   = '0;
          bit_cnt_d   = '0;
          state_d     = sTX_START;
        end else begin
          state_d = sIDLE;
        end
      end
      sTX_START: begin
        serial_d = 1'b0;
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = sTX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      sTX_DATA: begin
        serial_d = shift_q[0];
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = sTX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      sTX_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = sDONE;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = sIDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= sIDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      clk_cnt_q   <= '0;
      serial_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      clk_cnt_q   <= clk_cnt_d;
      serial_q    <= serial_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx.oTxReady = ~hold_full_q;
  assign oTxSerial   = serial_q;
  assign oTxBusy     = busy_q;
  assign oTxDone     = done_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

8N1 UART transmitter that serializes bytes onto a single TX line at `CLKS_PER_BIT` clocks per bit, LSB first. It is the transmit counterpart of the UART receiver in the same interface. A one-entry holding register behind a valid/ready handshake lets the next byte be queued while the current frame is on the line, so frames go out back-to-back.

## Interface
- `CLK_FREQ`, default 125_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in baud.
- `CLKS_PER_BIT`, default `CLK_FREQ / BAUD_RATE`: clocks per bit. Must be ≥ 2.
- `iClk`  in  1  clock; all logic on the rising edge.
- `iRst`  in  1  reset: synchronous, active-high.
- `iTxByte`  in  8  byte to send; sampled on handshake.
- `iTxValid`  in  1  source has a byte on `iTxByte`.
- `oTxReady`  out  1  holding register empty; a byte is accepted when `iTxValid & oTxReady`.
- `oTxSerial`  out  1  serial line; registered; idle high.
- `oTxBusy`  out  1  FSM not in sIDLE.
- `oTxDone`  out  1  one-cycle pulse after each frame's stop bit.

## Operation
- **Frame format:** start bit (0), data bits 0..7 (LSB first), stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- **Holding register (`rHold`, `rHoldFull`):** loads `iTxByte` and sets `rHoldFull` on handshake. `oTxReady = ~rHoldFull`.
- **Shift register:** 8 bits, shifts right once per data bit; `oTxSerial` takes bit 0.
- **Bit counter:** 3 bits, counts 0..7.
- **Clock counter:** `$clog2(CLKS_PER_BIT)+1` bits, counts 0..`CLKS_PER_BIT`-1, then wraps to 0.
- **FSM states and transitions:**
  - **sIDLE:** `oTxSerial`=1. If `rHoldFull`: load shift register from `rHold`, clear `rHoldFull`, clear counters, go to sTX_START.
  - **sTX_START:** `oTxSerial`=0 for `CLKS_PER_BIT` cycles, then go to sTX_DATA with bit counter 0.
  - **sTX_DATA:** `oTxSerial`=shift[0]. At clock count `CLKS_PER_BIT`-1: shift right and increment the bit counter. After bit 7 completes, go to sTX_STOP.
  - **sTX_STOP:** `oTxSerial`=1 for `CLKS_PER_BIT` cycles, then go to sDONE.
  - **sDONE:** one cycle; `oTxDone`=1, `oTxSerial`=1. If `rHoldFull`: load the shift register, clear `rHoldFull`, go straight to sTX_START. Otherwise go to sIDLE.
  - **Unknown state:** go to sIDLE, `oTxSerial`=1.
- **Handshake rules:**
  - A byte may be accepted in any state, including mid-frame, whenever `rHoldFull`=0.
  - When `rHoldFull`=1 the source must hold `iTxValid` and `iTxByte` stable. No byte is dropped or duplicated.
  - Acceptance and the hold→shift transfer never coincide, because `oTxReady` is low whenever a transfer can occur.
- **Reset (also applies mid-frame):** all state clears. `oTxSerial`=1, `oTxReady`=1, `oTxBusy`=0, `oTxDone`=0, FSM in sIDLE, holding register empty. A partial frame is abandoned with no `oTxDone`. Each output holds its reset value from the first edge with `iRst`=1.

## Timing
- N = `CLKS_PER_BIT`. Handshake at edge k, with the FSM in sIDLE:
  - Edge k+1: FSM enters sTX_START and `oTxReady` returns to 1. `oTxSerial` is driven 0 after edge k+2, since the output is registered.
  - Start bit occupies N cycles.
  - Data bit i occupies cycles [k+2+N(1+i), k+2+N(2+i)).
  - Stop bit occupies N cycles.
  - `oTxDone` is high for exactly 1 cycle, immediately after the stop bit.
- Idle-to-done latency is 10N+2 cycles from the accepting edge.
- **Back-to-back:** if a byte is queued before sDONE, the line stays high for exactly N+1 cycles (stop bit plus the sDONE cycle) before the next start bit.
- `oTxBusy` rises the cycle after sIDLE is left and falls the cycle after sDONE when nothing is queued.

## Test plan
All scenarios use N=16.
- **Reset values:** hold `iRst` for 3 cycles, then release. → `oTxSerial`=1, `oTxReady`=1, `oTxBusy`=0, `oTxDone`=0 throughout reset and while idle.
- **Single byte:** send 0xA5. → Line shows 0 for 16 cycles; bits 1,0,1,0,0,1,0,1, 16 cycles each; stop 1 for 16 cycles. Exactly one `oTxDone` pulse, 162 cycles after the accepting edge.
- **Back-to-back:** send 0x00, then 0xFF with `iTxValid` asserted during the first frame's data bits. → Second byte accepted once. Line high for exactly 17 cycles between frames. Two `oTxDone` pulses.
- **Backpressure:** hold `iTxValid`=1 with 0x11, 0x22, 0x33 in sequence. → `oTxReady` is low while the holding register is full. Output order is 0x11, 0x22, 0x33 with no loss or duplication.
- **Mid-frame reset:** assert `iRst` during data bit 3 of 0x5A with 0x77 queued. → `oTxSerial`=1 from the next cycle, `oTxBusy`=0, no `oTxDone`, and 0x77 is discarded.
- **Loopback:** connect `oTxSerial` to the UART receiver, both at N=16, and send 0x3C. → Receiver reports 0x3C with one done pulse.
